// File: rtl/tri_job_sched_if.sv
// Requester, engine and completion signals of tri_job_sched.
// TRI_SCHED_STATS_EN adds the stat_jobs / stat_pts outputs.
interface tri_job_sched_if #(parameter int NREQ = 2);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][17:0] req_tri;
  logic                  eng_nt;
  logic [2:0]            eng_xi;
  logic [2:0]            eng_yi;
  logic                  eng_busy;
  logic                  eng_po;
  logic                  done_valid;
  logic [1:0]            done_id;
  logic [6:0]            done_pts;
  logic                  idle;
`ifdef TRI_SCHED_STATS_EN
  logic [NREQ-1:0][15:0] stat_jobs;
  logic [15:0]           stat_pts;
`endif

  modport slave (
    input  req_valid, req_tri, eng_busy, eng_po,
    output req_ready, eng_nt, eng_xi, eng_yi, done_valid, done_id, done_pts, idle
`ifdef TRI_SCHED_STATS_EN
    , output stat_jobs, stat_pts
`endif
  );

  modport master (
    output req_valid, req_tri, eng_busy, eng_po,
    input  req_ready, eng_nt, eng_xi, eng_yi, done_valid, done_id, done_pts, idle
`ifdef TRI_SCHED_STATS_EN
    , input stat_jobs, stat_pts
`endif
  );
endinterface

// File: rtl/tri_job_sched.sv
// Round-robin triangle job scheduler: FIFO of whole triangles replayed to one engine.
// Optional TRI_SCHED_STATS_EN: per-requester job counts and total point count.
module tri_job_sched #(
  parameter int NREQ     = 2,
  parameter int FIFO_DEP = 4,
  parameter int WAIT_LAT = 4
) (
  input logic            clk,
  input logic            reset,
  tri_job_sched_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEP);
  localparam int WW = $clog2(WAIT_LAT + 1);

  typedef struct packed {
    logic [1:0] id;
    logic [2:0] x1, y1, x2, y2, x3, y3;
  } job_t;

  typedef enum logic [2:0] {S_IDLE, S_V1, S_V2, S_V3, S_WAIT, S_RUN, S_DONE} state_t;

  job_t          fifo_mem [FIFO_DEP];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop;
  job_t          head;

  logic [1:0]      rr_ptr;
  logic [NREQ-1:0] grant;
  logic [1:0]      gnt_id;
  logic [17:0]     gnt_tri;

  state_t        state;
  job_t          job;
  logic [6:0]    pts, pts_nx;
  logic [WW-1:0] wcnt;
  logic          nt_q, dv_q;
  logic [2:0]    xi_q, yi_q;
  logic [1:0]    did_q;
  logic [6:0]    dpts_q;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}});
  assign head  = fifo_mem[rd_ptr[PW-1:0]];

  // Smallest rotated distance from rr_ptr wins; grant is suppressed while full.
  always_comb begin
    int off, best;
    best    = NREQ;
    off     = 0;
    gnt_id  = '0;
    gnt_tri = '0;
    grant   = '0;
    for (int i = 0; i < NREQ; i++) begin
      off = (i + NREQ - int'(rr_ptr)) % NREQ;
      if (bus.req_valid[i] && off < best) begin
        best    = off;
        gnt_id  = 2'(i);
        gnt_tri = bus.req_tri[i];
      end
    end
    if (best < NREQ && !full && !reset)
      for (int i = 0; i < NREQ; i++) grant[i] = (gnt_id == 2'(i));
  end

  assign push = |grant;
  assign pop  = (state == S_IDLE) && !empty && !bus.eng_busy;

  // po is counted in WAIT and RUN, including the cycle busy falls.
  assign pts_nx = (bus.eng_po && pts != 7'd64) ? pts + 7'd1 : pts;

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= {gnt_id, gnt_tri};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr_ptr <= '0;
      state  <= S_IDLE;
      job    <= '0;
      pts    <= '0;
      wcnt   <= '0;
      nt_q   <= 1'b0;
      xi_q   <= '0;
      yi_q   <= '0;
      dv_q   <= 1'b0;
      did_q  <= '0;
      dpts_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= 2'((int'(gnt_id) + 1) % NREQ);
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      nt_q   <= 1'b0;
      xi_q   <= '0;
      yi_q   <= '0;
      dv_q   <= 1'b0;
      did_q  <= '0;
      dpts_q <= '0;

      case (state)
        S_IDLE: if (pop) begin
          job   <= head;
          state <= S_V1;
          nt_q  <= 1'b1;
          xi_q  <= head.x1;
          yi_q  <= head.y1;
        end
        S_V1: begin
          state <= S_V2;
          xi_q  <= job.x2;
          yi_q  <= job.y2;
        end
        S_V2: begin
          state <= S_V3;
          xi_q  <= job.x3;
          yi_q  <= job.y3;
        end
        S_V3: begin
          state <= S_WAIT;
          wcnt  <= '0;
          pts   <= '0;
        end
        S_WAIT: begin
          pts <= pts_nx;
          if (bus.eng_busy) state <= S_RUN;
          else if (wcnt == WW'(WAIT_LAT - 1)) begin
            state  <= S_DONE;
            dv_q   <= 1'b1;
            did_q  <= job.id;
            dpts_q <= pts_nx;
          end else wcnt <= wcnt + 1'b1;
        end
        S_RUN: begin
          pts <= pts_nx;
          if (!bus.eng_busy) begin
            state  <= S_DONE;
            dv_q   <= 1'b1;
            did_q  <= job.id;
            dpts_q <= pts_nx;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          pts   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = grant;
  assign bus.eng_nt     = nt_q;
  assign bus.eng_xi     = xi_q;
  assign bus.eng_yi     = yi_q;
  assign bus.done_valid = dv_q;
  assign bus.done_id    = did_q;
  assign bus.done_pts   = dpts_q;
  assign bus.idle       = (state == S_IDLE) && empty;

`ifdef TRI_SCHED_STATS_EN
  logic [NREQ-1:0][15:0] stat_jobs_q;
  logic [15:0]           stat_pts_q;

  // The DONE-state record is folded in at its closing edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_jobs_q <= '0;
      stat_pts_q  <= '0;
    end else if (state == S_DONE) begin
      stat_pts_q <= stat_pts_q + 16'(dpts_q);
      for (int i = 0; i < NREQ; i++)
        if (did_q == 2'(i)) stat_jobs_q[i] <= stat_jobs_q[i] + 16'd1;
    end
  end

  assign bus.stat_jobs = stat_jobs_q;
  assign bus.stat_pts  = stat_pts_q;
`endif
endmodule
